trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 186 ++++++++++++++++++
 tb/tb_trace_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// Instruction-retire trace buffer: captures retiring instructions into a circular
// memory under wrap / stop / trigger policies, then drains them oldest-first once frozen.
module trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_ins,
    input  logic [DATA_W-1:0] cap_wdata,
    input  logic              cap_wen,
    input  logic [REG_AW-1:0] cap_wreg,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [AW-1:0]     post_cnt,
    input  logic              arm,
    input  logic              freeze,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_ins,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_wen,
    output logic [REG_AW-1:0] out_wreg,
    output logic [1:0]        state,
    output logic [AW:0]       count,
    output logic              overflow
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] CAPTURE = 2'b01;
    localparam logic [1:0] POST    = 2'b10;
    localparam logic [1:0] FROZEN  = 2'b11;

    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_STOP = 2'd2;
    localparam logic [1:0] M_TRIG = 2'd3;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] ins;
        logic              wen;
        logic [REG_AW-1:0] wreg;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            wr_ent;
    entry_t            rd_ent;

    logic [1:0]        st_q, st_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] trig_q, trig_d;
    // Holds the sampled post_cnt until the trigger, then counts remaining post entries.
    logic [AW-1:0]     post_q, post_d;
    logic              we;
    logic              full;
    logic              xfer;

    assign full   = (cnt_q == FULL);
    assign xfer   = out_valid && out_ready;
    assign wr_ent = '{pc: cap_pc, ins: cap_ins, wen: cap_wen, wreg: cap_wreg, wdata: cap_wdata};

    always_comb begin
        st_d   = st_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        mode_d = mode_q;
        trig_d = trig_q;
        post_d = post_q;
        we     = 1'b0;

        if (clear) begin
            st_d   = IDLE;
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (arm) begin
            // Arming always discards content; mode 0 simply parks the block in IDLE.
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            if (mode != M_OFF) begin
                st_d   = CAPTURE;
                ovf_d  = 1'b0;
                mode_d = mode;
                trig_d = trig_pc;
                post_d = post_cnt;
            end else begin
                st_d   = IDLE;
            end
        end else begin
            case (st_q)
                CAPTURE, POST: begin
                    if (cap_valid) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        if (full) begin
                            rptr_d = rptr_q + 1'b1;
                            ovf_d  = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                        end
                        if (st_q == CAPTURE) begin
                            if (mode_q == M_STOP && cnt_q == FULL - 1'b1)
                                st_d = FROZEN;
                            if (mode_q == M_TRIG && cap_pc == trig_q)
                                st_d = (post_q == '0) ? FROZEN : POST;
                        end else begin
                            post_d = post_q - 1'b1;
                            if (post_q == AW'(1))
                                st_d = FROZEN;
                        end
                    end
                    if (freeze)
                        st_d = FROZEN;
                    if (st_d == FROZEN && cnt_d == '0)
                        st_d = IDLE;
                end
                FROZEN: begin
                    if (xfer) begin
                        rptr_d = rptr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                        if (cnt_q == (AW+1)'(1))
                            st_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            st_q   <= IDLE;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            mode_q <= M_OFF;
            trig_q <= '0;
            post_q <= '0;
        end else begin
            st_q   <= st_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            mode_q <= mode_d;
            trig_q <= trig_d;
            post_q <= post_d;
        end
    end

    // Trace storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (we)
            mem[wptr_q] <= wr_ent;
    end

    assign rd_ent    = mem[rptr_q];
    assign out_valid = (st_q == FROZEN) && (cnt_q != '0);
    assign out_pc    = rd_ent.pc;
    assign out_ins   = rd_ent.ins;
    assign out_wdata = rd_ent.wdata;
    assign out_wen   = rd_ent.wen;
    assign out_wreg  = rd_ent.wreg;
    assign state     = st_q;
    assign count     = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Randomized + directed bench for trace_buffer, checked every cycle against a
// queue-based reference model of the capture/drain rules.
module tb_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int AW     = 4;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic              cap_valid = 1'b0;
    logic [DATA_W-1:0] cap_pc = '0, cap_ins = '0, cap_wdata = '0;
    logic              cap_wen = 1'b0;
    logic [REG_AW-1:0] cap_wreg = '0;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] trig_pc = '0;
    logic [AW-1:0]     post_cnt = '0;
    logic              arm = 1'b0, freeze = 1'b0, clear = 1'b0;
    logic              out_valid, out_ready = 1'b0;
    logic [DATA_W-1:0] out_pc, out_ins, out_wdata;
    logic              out_wen;
    logic [REG_AW-1:0] out_wreg;
    logic [1:0]        state;
    logic [AW:0]       count;
    logic              overflow;

    always #5 CLK = ~CLK;

    trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .CLK(CLK), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_ins(cap_ins), .cap_wdata(cap_wdata), .cap_wen(cap_wen), .cap_wreg(cap_wreg),
        .mode(mode), .trig_pc(trig_pc), .post_cnt(post_cnt), .arm(arm),
        .freeze(freeze), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ins(out_ins), .out_wdata(out_wdata), .out_wen(out_wen),
        .out_wreg(out_wreg), .state(state), .count(count), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] pc, ins, wdata;
        logic        wen;
        logic [4:0]  wreg;
    } ent_t;

    // Reference model: 0 IDLE, 1 CAPTURE, 2 POST, 3 FROZEN
    ent_t        q[$];
    int          mst = 0;
    bit          movf = 0;
    int          mmode = 0;
    logic [31:0] mtrig = '0;
    int          mpost = 0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] drained[$];

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            q.delete(); mst = 0; movf = 0;
        end else if (clear) begin
            q.delete(); mst = 0; movf = 0;
        end else if (arm) begin
            q.delete();
            if (mode != 0) begin
                mst = 1; movf = 0; mmode = int'(mode); mtrig = trig_pc; mpost = int'(post_cnt);
            end else mst = 0;
        end else if (mst == 1 || mst == 2) begin
            int   ns;
            ent_t e;
            ns = mst;
            if (cap_valid) begin
                e.pc = cap_pc; e.ins = cap_ins; e.wdata = cap_wdata; e.wen = cap_wen; e.wreg = cap_wreg;
                q.push_back(e);
                if (q.size() > DEPTH) begin void'(q.pop_front()); movf = 1; end
                if (mst == 1 && mmode == 2 && q.size() == DEPTH) ns = 3;
                if (mst == 1 && mmode == 3 && cap_pc == mtrig) ns = (mpost == 0) ? 3 : 2;
                if (mst == 2) begin mpost--; if (mpost == 0) ns = 3; end
            end
            if (freeze) ns = 3;
            if (ns == 3 && q.size() == 0) ns = 0;
            mst = ns;
        end else if (mst == 3) begin
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) mst = 0;
            end
        end
    end

    always @(negedge CLK) begin
        bit ov;
        bit bad;
        ov = (mst == 3) && (q.size() > 0);
        bad = (state !== 2'(mst)) || (count !== 5'(q.size())) || (overflow !== movf) || (out_valid !== ov);
        if (ov && !bad)
            bad = (out_pc !== q[0].pc) || (out_ins !== q[0].ins) || (out_wdata !== q[0].wdata) ||
                  (out_wen !== q[0].wen) || (out_wreg !== q[0].wreg);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL model t=%0t: state %0d want %0d, count %0d want %0d, ovf %0b want %0b, valid %0b want %0b, pc %h want %h",
                     $time, state, mst, count, q.size(), overflow, movf, out_valid, ov, out_pc,
                     (q.size() > 0) ? q[0].pc : 32'h0);
        end
        if (out_valid && out_ready) drained.push_back(out_pc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #2;
        arm = 0; freeze = 0; clear = 0; cap_valid = 0;
    endtask

    task automatic capture(input logic [31:0] pc);
        cap_valid = 1; cap_pc = pc; cap_ins = $urandom; cap_wdata = $urandom;
        cap_wen = 1'($urandom_range(0, 1)); cap_wreg = 5'($urandom_range(0, 31));
        tick();
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [31:0] tp, input logic [3:0] pc_n);
        arm = 1; mode = m; trig_pc = tp; post_cnt = pc_n; tick();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (state != 2'b00 && n < budget) begin tick(); n++; end
        chk("drain_done", {31'b0, state == 2'b00}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_state", {30'b0, state}, 32'd0);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        reset = 1;
        tick();

        // Wrap mode: 20 captures keep the newest 16
        out_ready = 0;
        do_arm(2'd1, '0, '0);
        for (int k = 0; k < 20; k++) capture(BASE + 32'(4 * k));
        freeze = 1; tick();
        chk("wrap_state", {30'b0, state}, 32'd3);
        chk("wrap_count", {27'b0, count}, 32'd16);
        chk("wrap_ovf", {31'b0, overflow}, 32'd1);
        drained.delete(); out_ready = 1;
        wait_idle(40);
        chk("wrap_ndrain", drained.size(), 32'd16);
        for (int i = 0; i < 16; i++)
            chk("wrap_pc", (i < drained.size()) ? drained[i] : 32'hx, BASE + 32'h10 + 32'(4 * i));
        chk("wrap_ovf_kept", {31'b0, overflow}, 32'd1);

        // Stop mode: freezes on the 16th capture, nothing overwritten
        out_ready = 0;
        do_arm(2'd2, '0, '0);
        for (int k = 0; k < 16; k++) capture(BASE + 32'(4 * k));
        chk("stop_state", {30'b0, state}, 32'd3);
        chk("stop_count", {27'b0, count}, 32'd16);
        chk("stop_ovf", {31'b0, overflow}, 32'd0);
        for (int k = 16; k < 20; k++) capture(BASE + 32'(4 * k));
        chk("stop_count_hold", {27'b0, count}, 32'd16);
        drained.delete(); out_ready = 1;
        wait_idle(40);
        chk("stop_ndrain", drained.size(), 32'd16);
        chk("stop_last", (drained.size() > 0) ? drained[drained.size()-1] : 32'hx, 32'h0040_003C);

        // Trigger mode: trigger at 0x20, three post entries
        out_ready = 0;
        do_arm(2'd3, 32'h0040_0020, 4'd3);
        for (int k = 0; k < 11; k++) capture(BASE + 32'(4 * k));
        chk("trig_post", {30'b0, state}, 32'd2);
        capture(BASE + 32'(4 * 11));
        chk("trig_frozen", {30'b0, state}, 32'd3);
        chk("trig_count", {27'b0, count}, 32'd12);
        drained.delete(); out_ready = 1;
        wait_idle(40);
        chk("trig_ndrain", drained.size(), 32'd12);
        chk("trig_entry", (drained.size() > 8) ? drained[8] : 32'hx, 32'h0040_0020);
        chk("trig_last", (drained.size() > 0) ? drained[drained.size()-1] : 32'hx, 32'h0040_002C);

        // Backpressure: out_ready toggles during the drain of 4 entries
        out_ready = 0;
        do_arm(2'd1, '0, '0);
        for (int k = 0; k < 4; k++) capture(BASE + 32'h100 + 32'(4 * k));
        freeze = 1; tick();
        drained.delete();
        out_ready = 1;
        for (int n = 0; n < 20 && state != 2'b00; n++) begin tick(); out_ready = ~out_ready; end
        chk("bp_ndrain", drained.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("bp_pc", (i < drained.size()) ? drained[i] : 32'hx, BASE + 32'h100 + 32'(4 * i));
        out_ready = 0;

        // Clear and arm together while capturing
        do_arm(2'd1, '0, '0);
        for (int k = 0; k < 3; k++) capture(BASE + 32'(4 * k));
        clear = 1; arm = 1; mode = 2'd1; tick();
        chk("clr_arm_state", {30'b0, state}, 32'd0);
        chk("clr_arm_count", {27'b0, count}, 32'd0);

        // Reset mid-drain acts without a clock edge
        do_arm(2'd1, '0, '0);
        for (int k = 0; k < 5; k++) capture(BASE + 32'(4 * k));
        freeze = 1; tick();
        out_ready = 1; tick();
        reset = 0; #1;
        chk("rst_mid_state", {30'b0, state}, 32'd0);
        chk("rst_mid_count", {27'b0, count}, 32'd0);
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        tick(); reset = 1; tick();

        // Random traffic
        for (int it = 0; it < 4000; it++) begin
            arm       = ($urandom_range(0, 39) == 0);
            mode      = 2'($urandom_range(0, 3));
            freeze    = ($urandom_range(0, 59) == 0);
            clear     = ($urandom_range(0, 249) == 0);
            cap_valid = 1'($urandom_range(0, 1));
            cap_pc    = BASE + 32'(4 * $urandom_range(0, 7));
            cap_ins   = $urandom; cap_wdata = $urandom;
            cap_wen   = 1'($urandom_range(0, 1)); cap_wreg = 5'($urandom_range(0, 31));
            trig_pc   = BASE + 32'(4 * $urandom_range(0, 7));
            post_cnt  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 699) == 0) begin
                reset = 0; tick(); reset = 1;
            end else begin
                @(posedge CLK); #2;
            end
        end
        arm = 0; freeze = 0; clear = 0; cap_valid = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
